// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the RED -> GREEN -> YELLOW lamp code stream.
// Decodes lamp codes, tracks sequence lock, flags errors and counts completed cycles.
module lamp_sequence_monitor #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       light,
  input  logic             clear_err,
  output logic             red,
  output logic             green,
  output logic             yellow,
  output logic             locked,
  output logic             seq_err,
  output logic             illegal_code,
  output logic             sticky_err,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [2:0] CODE_RED    = 3'b000;
  localparam logic [2:0] CODE_GREEN  = 3'b001;
  localparam logic [2:0] CODE_YELLOW = 3'b010;

  state_t           state_q, state_d;
  logic [2:0]       expect_q, expect_d;
  logic             red_q, red_d;
  logic             green_q, green_d;
  logic             yellow_q, yellow_d;
  logic             seq_err_q, seq_err_d;
  logic             illegal_q, illegal_d;
  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             legal;
  logic             err_event;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      expect_q      <= CODE_GREEN;
      red_q         <= 1'b0;
      green_q       <= 1'b0;
      yellow_q      <= 1'b0;
      seq_err_q     <= 1'b0;
      illegal_q     <= 1'b0;
      sticky_q      <= 1'b0;
      err_count_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      expect_q      <= expect_d;
      red_q         <= red_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      seq_err_q     <= seq_err_d;
      illegal_q     <= illegal_d;
      sticky_q      <= sticky_d;
      err_count_q   <= err_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    expect_d      = expect_q;
    red_d         = red_q;
    green_d       = green_q;
    yellow_d      = yellow_q;
    seq_err_d     = 1'b0;
    illegal_d     = 1'b0;
    sticky_d      = sticky_q;
    err_count_d   = err_count_q;
    cycle_count_d = cycle_count_q;
    err_event     = 1'b0;
    legal         = (light == CODE_RED) || (light == CODE_GREEN) || (light == CODE_YELLOW);

    if (en) begin
      if (!legal) begin
        illegal_d = 1'b1;
        err_event = 1'b1;
        red_d     = 1'b0;
        green_d   = 1'b0;
        yellow_d  = 1'b0;
        state_d   = HUNT;
      end else begin
        red_d    = (light == CODE_RED);
        green_d  = (light == CODE_GREEN);
        yellow_d = (light == CODE_YELLOW);
        case (state_q)
          HUNT: begin
            if (light == CODE_RED) begin
              state_d  = TRACK;
              expect_d = CODE_GREEN;
            end
          end
          TRACK: begin
            if (light == expect_q) begin
              case (expect_q)
                CODE_GREEN:  expect_d = CODE_YELLOW;
                CODE_YELLOW: begin
                  expect_d      = CODE_RED;
                  cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                default:     expect_d = CODE_GREEN;
              endcase
            end else begin
              seq_err_d = 1'b1;
              err_event = 1'b1;
              if (light == CODE_RED) begin
                expect_d = CODE_GREEN;
              end else begin
                state_d = HUNT;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end

    // A new error outranks clear_err, so a simultaneous clear restarts the count at one.
    if (err_event) begin
      sticky_d = 1'b1;
      if (clear_err) begin
        err_count_d = ERR_W'(1);
      end else if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end else if (clear_err) begin
      sticky_d    = 1'b0;
      err_count_d = '0;
    end
  end

  assign red          = red_q;
  assign green        = green_q;
  assign yellow       = yellow_q;
  assign locked       = (state_q == TRACK);
  assign seq_err      = seq_err_q;
  assign illegal_code = illegal_q;
  assign sticky_err   = sticky_q;
  assign err_count    = err_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed self-checking bench for lamp_sequence_monitor.
// A narrow cycle counter is used so the wrap-around can be reached quickly.
module tb_lamp_sequence_monitor;

  localparam int CNT_W = 4;
  localparam int ERR_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       light;
  logic             clear_err;
  logic             red;
  logic             green;
  logic             yellow;
  logic             locked;
  logic             seq_err;
  logic             illegal_code;
  logic             sticky_err;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] cycle_count;

  int checkCount = 0;
  int errorCount = 0;

  lamp_sequence_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .light(light),
    .clear_err(clear_err),
    .red(red),
    .green(green),
    .yellow(yellow),
    .locked(locked),
    .seq_err(seq_err),
    .illegal_code(illegal_code),
    .sticky_err(sticky_err),
    .err_count(err_count),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs, then sample outputs 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] l, input logic c);
    rst       = r;
    en        = e;
    light     = l;
    clear_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkDecode(input string tag, input logic [2:0] rgy);
    checkOutput(tag, {29'd0, red, green, yellow}, {29'd0, rgy});
  endtask

  task automatic checkFlags(input string tag, input logic lk, input logic se, input logic ic, input logic st);
    checkOutput(tag, {28'd0, locked, seq_err, illegal_code, sticky_err}, {28'd0, lk, se, ic, st});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; light = 3'b000; clear_err = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0);
    checkDecode("reset_decode", 3'b000);
    checkFlags("reset_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_errcnt", 32'(err_count), 32'd0);
    checkOutput("reset_cyccnt", 32'(cycle_count), 32'd0);

    // Four clean R-G-Y cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
      checkDecode("clean_red", 3'b100);
      checkFlags("clean_lock", 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
      checkDecode("clean_green", 3'b010);
      applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
      checkDecode("clean_yellow", 3'b001);
      checkOutput("clean_cyccnt", 32'(cycle_count), 32'(i + 1));
    end
    checkOutput("clean_errcnt", 32'(err_count), 32'd0);
    checkFlags("clean_flags", 1'b1, 1'b0, 1'b0, 1'b0);

    // RED then YELLOW: out of order, drops to HUNT
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    checkFlags("skip_flags", 1'b0, 1'b1, 1'b0, 1'b1);
    checkDecode("skip_decode", 3'b001);
    checkOutput("skip_errcnt", 32'(err_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b010, 1'b0);
    checkFlags("skip_pulse_end", 1'b0, 1'b0, 1'b0, 1'b1);

    // Relock, then an early RED resyncs while staying locked
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    checkFlags("relock", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    checkFlags("resync_flags", 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("resync_errcnt", 32'(err_count), 32'd2);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    checkOutput("resync_cyccnt", 32'(cycle_count), 32'd5);
    checkFlags("resync_after", 1'b1, 1'b0, 1'b0, 1'b1);

    // clear_err with no sample in flight
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("clear_errcnt", 32'(err_count), 32'd0);
    checkFlags("clear_flags", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clear_cyccnt", 32'(cycle_count), 32'd5);

    // Back-to-back illegal codes
    applyStimulus(1'b0, 1'b1, 3'b111, 1'b0);
    checkFlags("ill1_flags", 1'b0, 1'b0, 1'b1, 1'b1);
    checkDecode("ill1_decode", 3'b000);
    applyStimulus(1'b0, 1'b1, 3'b100, 1'b0);
    checkFlags("ill2_flags", 1'b0, 1'b0, 1'b1, 1'b1);
    checkDecode("ill2_decode", 3'b000);
    checkOutput("ill_errcnt", 32'(err_count), 32'd2);

    // Saturation, then clear_err colliding with a seq_err
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 3'b101, 1'b0);
    checkOutput("sat_errcnt", 32'(err_count), 32'd255);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    checkOutput("sat_hold", 32'(err_count), 32'd255);
    checkFlags("sat_lock", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b1);
    checkOutput("clr_vs_err_cnt", 32'(err_count), 32'd1);
    checkFlags("clr_vs_err_flags", 1'b0, 1'b1, 1'b0, 1'b1);

    // en gaps hold state, then reset mid-cycle
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b011, 1'b0);
    checkDecode("gap1_decode", 3'b100);
    checkFlags("gap1_flags", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b0, 3'b111, 1'b0);
    checkDecode("gap2_decode", 3'b010);
    checkFlags("gap2_flags", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("gap2_errcnt", 32'(err_count), 32'd1);
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0);
    checkDecode("rst_decode", 3'b000);
    checkFlags("rst_flags", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_errcnt", 32'(err_count), 32'd0);
    checkOutput("rst_cyccnt", 32'(cycle_count), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    checkOutput("post_rst_nocount", 32'(cycle_count), 32'd0);
    checkFlags("post_rst_hunt", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    checkOutput("post_rst_count", 32'(cycle_count), 32'd1);

    // Fifteen more cycles wrap the 4-bit counter to zero
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'b001, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'b010, 1'b0);
    end
    checkOutput("wrap_cyccnt", 32'(cycle_count), 32'd0);
    checkOutput("wrap_errcnt", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
Receive-side checker for the cyclic lamp code stream (RED=3'b000 -> GREEN=3'b001 -> YELLOW=3'b010 -> RED ...).
- Decodes each sampled 3-bit code to one-hot lamp drives.
- Locks onto the sequence, flags out-of-order and illegal codes, and counts completed R-G-Y cycles.
- Sits downstream of the lamp generator, in the same clock domain, as a status source for the lamp controller.

Parameters:
CNT_W, 16, width of completed-cycle counter (wraps)
ERR_W, 8, width of error counter (saturates)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  sample strobe; light is sampled only when en=1
light  input  3  lamp code from generator: 000 RED, 001 GREEN, 010 YELLOW, others illegal
clear_err  input  1  synchronous clear of sticky_err and err_count
red  output  1  registered one-hot decode of last legal sampled code
green  output  1  registered one-hot decode
yellow  output  1  registered one-hot decode
locked  output  1  1 while FSM in TRACK
seq_err  output  1  1-cycle pulse: legal code out of order while in TRACK
illegal_code  output  1  1-cycle pulse: code not in {000,001,010} sampled (any state)
sticky_err  output  1  set by any seq_err/illegal_code, held until clear_err or rst
err_count  output  ERR_W  number of erroneous samples, saturates at all-ones
cycle_count  output  CNT_W  completed R-G-Y cycles, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high.
- Reset values: all outputs 0; FSM in HUNT; expected code = GREEN.
- Latency: every output reflects the sample taken at an en=1 edge starting the following cycle (1-cycle registered).

FSM states: HUNT, TRACK. Transitions and actions below happen only on edges with en=1.
- HUNT, light==RED: go to TRACK, expected=GREEN.
- HUNT, other legal code: stay in HUNT, no error.
- HUNT, illegal code: illegal_code pulse, error counted, stay in HUNT.
- TRACK, light==expected: advance expected (GREEN->YELLOW->RED->GREEN).
  - Matching YELLOW increments cycle_count.
- TRACK, legal code != expected: seq_err pulse, error counted.
  - If light==RED: resync, stay in TRACK with expected=GREEN.
  - Otherwise: go to HUNT.
- TRACK, illegal code: illegal_code pulse only (seq_err stays 0), error counted, go to HUNT.

Error counting:
- At most one err_count increment per sample.
- Saturates at 2^ERR_W-1; no wrap.
- sticky_err=1 whenever a sample is counted as an error.

Decode outputs:
- Updated on every en=1 sample carrying a legal code, in any state; exactly one of red/green/yellow is then high.
- Illegal code: all three forced to 0.
- en=0: all three hold.

Other timing:
- en=0: FSM, counters and decode hold; seq_err=illegal_code=0.
- Pulses last exactly one cycle per offending sample. Back-to-back bad samples give back-to-back pulses.
- clear_err same cycle as a new error: the error wins. err_count becomes 1 (not old+1), sticky_err=1.
- clear_err does not affect FSM or cycle_count.
- rst mid-sequence: next cycle all outputs 0, HUNT. The first cycle counts only after a fresh RED then GREEN then YELLOW.
- cycle_count at all-ones plus one completed cycle wraps to 0.

Test Plan:
- rst, then en=1 with codes 000,001,010 repeated 4 times -> locked=1 from the cycle after the first RED; cycle_count=4; err_count=0; sticky_err=0; red/green/yellow track each code with 1-cycle lag.
- Locked stream, sample sequence 000,010 -> seq_err pulse 1 cycle after the 010 sample; FSM goes to HUNT; locked=0; err_count=1; sticky_err=1; yellow=1.
- Locked, expecting GREEN, inject 000 -> seq_err pulse; locked stays 1; next samples 001,010 increment cycle_count by 1.
- Inject 3'b111 while locked, then 3'b100 in HUNT -> two consecutive illegal_code pulses; seq_err=0; red=green=yellow=0; err_count=2; locked=0.
- Force 300 illegal samples with ERR_W=8 -> err_count saturates at 255. Then clear_err on the same edge as a seq_err -> err_count=1, sticky_err=1.
- Toggle en=0 between samples of a legal sequence, and assert rst mid-cycle after 000,001 -> holds during en=0 with no pulses. After rst: all outputs 0. Subsequent 001,010 give no cycle count; 000,001,010 gives cycle_count=1.
